// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - serial-to-parallel receiver with frame-start alignment and one-word output holding register
module sipo_deframer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_bit_in,
    input  logic             i_bit_vld,
    input  logic             i_frm_start,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_vld,
    input  logic             i_dout_rdy,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_frm_err
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;
    logic             r_overrun;
    logic             r_frm_err;

    logic             w_restart;
    logic             w_capture;
    logic [CNT_W-1:0] w_bit_idx;
    logic [WIDTH-1:0] w_sr_base;
    logic [WIDTH-1:0] w_sr_next;
    logic             w_complete;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;

    // A strobed frm_start always begins a new word; other strobed bits only count inside a frame.
    assign w_restart  = i_bit_vld & i_frm_start;
    assign w_capture  = i_bit_vld & ((r_state == ST_SHIFT) | i_frm_start);
    // Index of the bit being captured on this edge; a restart discards the partial word.
    assign w_bit_idx  = w_restart ? '0 : r_cnt;
    assign w_sr_base  = w_restart ? '0 : r_sr;
    assign w_complete = w_capture & (w_bit_idx == LAST_IDX);

    // Output slot: free if empty or being consumed on this edge, otherwise a new word is lost.
    assign w_accept   = r_dout_vld & i_dout_rdy;
    assign w_load     = w_complete & (~r_dout_vld | i_dout_rdy);
    assign w_drop     = w_complete & r_dout_vld & ~i_dout_rdy;

    // Next shift-register value with the incoming bit placed according to bit order.
    always_comb begin
        w_sr_next = w_sr_base;
        if (MSB_FIRST) begin
            w_sr_next = {w_sr_base[WIDTH-2:0], i_bit_in};
        end else begin
            w_sr_next = {i_bit_in, w_sr_base[WIDTH-1:1]};
        end
    end

    // Receive FSM, shift register, output holding register and error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_sr       <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_overrun  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_frm_err <= w_restart & (r_state == ST_SHIFT);

            if (w_capture) begin
                r_sr <= w_sr_next;
                if (w_complete) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= ST_SHIFT;
                    r_cnt   <= w_bit_idx + 1'b1;
                end
            end

            if (w_load) begin
                r_dout     <= w_sr_next;
                r_dout_vld <= 1'b1;
            end else if (w_accept) begin
                r_dout_vld <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_dout_vld = r_dout_vld;
    assign o_busy     = (r_state == ST_SHIFT);
    assign o_overrun  = r_overrun;
    assign o_frm_err  = r_frm_err;

endmodule

// File: tb/tb_sipo_deframer.sv
// tb/tb_sipo_deframer.sv - scoreboard bench for sipo_deframer, MSB-first and LSB-first builds side by side
module tb_sipo_deframer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       frm_start = 1'b0;
    logic       clr_err = 1'b0;
    logic       dout_rdy = 1'b0;

    logic [7:0] dout_m, dout_l;
    logic       vld_m, vld_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deframer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_in(bit_in), .i_bit_vld(bit_vld),
        .i_frm_start(frm_start), .i_clr_err(clr_err), .o_dout(dout_m), .o_dout_vld(vld_m),
        .i_dout_rdy(dout_rdy), .o_busy(busy_m), .o_overrun(ovr_m), .o_frm_err(ferr_m)
    );

    sipo_deframer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_bit_in(bit_in), .i_bit_vld(bit_vld),
        .i_frm_start(frm_start), .i_clr_err(clr_err), .o_dout(dout_l), .o_dout_vld(vld_l),
        .i_dout_rdy(dout_rdy), .o_busy(busy_l), .o_overrun(ovr_l), .o_frm_err(ferr_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // One clock: consume any word handed over on this edge from the scoreboard, then advance.
    task automatic tick();
        logic [7:0] e;
        if (vld_m && dout_rdy) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL sb_msb spurious word %h with empty queue", dout_m);
            end else begin
                e = q_m.pop_front();
                if (dout_m !== e) begin
                    errors++;
                    $display("FAIL sb_msb got %h expected %h", dout_m, e);
                end
            end
        end
        if (vld_l && dout_rdy) begin
            checks++;
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL sb_lsb spurious word %h with empty queue", dout_l);
            end else begin
                e = q_l.pop_front();
                if (dout_l !== e) begin
                    errors++;
                    $display("FAIL sb_lsb got %h expected %h", dout_l, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Send a full 8-bit frame MSB first on the wire; counts busy and frm_err cycles seen.
    task automatic send_word(input logic [7:0] w, input int gap, input bit push, input bit rdy_last,
                             output int busy_n, output int err_n);
        if (push) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        busy_n = 0;
        err_n  = 0;
        for (int k = 0; k < 8; k++) begin
            bit_vld   = 1'b1;
            bit_in    = w[7-k];
            frm_start = (k == 0);
            if (k == 7 && rdy_last) dout_rdy = 1'b1;
            tick();
            bit_vld   = 1'b0;
            frm_start = 1'b0;
            bit_in    = 1'b0;
            busy_n += int'(busy_m);
            err_n  += int'(ferr_m);
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    busy_n += int'(busy_m);
                    err_n  += int'(ferr_m);
                end
            end
        end
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) begin
            bit_vld   = 1'b1;
            bit_in    = k[0];
            frm_start = (k == 0);
            tick();
            bit_vld   = 1'b0;
            frm_start = 1'b0;
            bit_in    = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({dout_m, vld_m, busy_m, ovr_m, ferr_m, dout_l, vld_l, busy_l, ovr_l, ferr_l} !== '0) begin
            errors++;
            $display("FAIL reset_state msb=%h/%b%b%b%b lsb=%h/%b%b%b%b expected all 0",
                     dout_m, vld_m, busy_m, ovr_m, ferr_m, dout_l, vld_l, busy_l, ovr_l, ferr_l);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b, e;
        dout_rdy = 1'b1;
        send_word(8'hA5, 0, 1'b1, 1'b0, b, e);
        checks++;
        if (vld_m !== 1'b1 || dout_m !== 8'hA5) begin
            errors++;
            $display("FAIL single_word vld=%b dout=%h expected 1/a5", vld_m, dout_m);
        end
        checks++;
        if (b != 7) begin
            errors++;
            $display("FAIL single_busy cycles=%0d expected 7", b);
        end
        tick();
        checks++;
        if (vld_m !== 1'b0) begin
            errors++;
            $display("FAIL single_vld_pulse vld=%b expected 0", vld_m);
        end
    endtask

    task automatic test_gapped();
        int b, e;
        dout_rdy = 1'b1;
        send_word(8'hA5, 2, 1'b1, 1'b0, b, e);
        checks++;
        if (vld_m !== 1'b1 || dout_m !== 8'hA5) begin
            errors++;
            $display("FAIL gapped_word vld=%b dout=%h expected 1/a5", vld_m, dout_m);
        end
        checks++;
        if (b != 21 || e != 0) begin
            errors++;
            $display("FAIL gapped_busy busy=%0d frm_err=%0d expected 21/0", b, e);
        end
        tick();
    endtask

    task automatic test_overrun();
        int b, e;
        dout_rdy = 1'b0;
        send_word(8'h3C, 0, 1'b1, 1'b0, b, e);
        checks++;
        if (vld_m !== 1'b1 || ovr_m !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first vld=%b overrun=%b expected 1/0", vld_m, ovr_m);
        end
        send_word(8'hC3, 0, 1'b0, 1'b0, b, e);
        checks++;
        if (dout_m !== 8'h3C || ovr_m !== 1'b1 || ovr_l !== 1'b1) begin
            errors++;
            $display("FAIL ovr_drop dout=%h overrun=%b/%b expected 3c/1/1", dout_m, ovr_m, ovr_l);
        end
        dout_rdy = 1'b1;
        tick();
        dout_rdy = 1'b0;
        checks++;
        if (vld_m !== 1'b0 || ovr_m !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept vld=%b overrun=%b expected 0/1", vld_m, ovr_m);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear overrun=%b/%b expected 0/0", ovr_m, ovr_l);
        end
    endtask

    task automatic test_abort();
        int b, e;
        dout_rdy = 1'b1;
        send_partial(5);
        checks++;
        if (busy_m !== 1'b1 || ferr_m !== 1'b0) begin
            errors++;
            $display("FAIL abort_partial busy=%b frm_err=%b expected 1/0", busy_m, ferr_m);
        end
        send_word(8'h0F, 0, 1'b1, 1'b0, b, e);
        checks++;
        if (e != 1) begin
            errors++;
            $display("FAIL abort_frm_err cycles=%0d expected 1", e);
        end
        checks++;
        if (vld_m !== 1'b1 || dout_m !== 8'h0F) begin
            errors++;
            $display("FAIL abort_word vld=%b dout=%h expected 1/0f", vld_m, dout_m);
        end
        tick();
    endtask

    task automatic test_bit_order();
        int b, e;
        dout_rdy = 1'b1;
        send_word(8'hC0, 0, 1'b1, 1'b0, b, e);
        checks++;
        if (dout_m !== 8'hC0 || dout_l !== 8'h03) begin
            errors++;
            $display("FAIL bit_order msb=%h lsb=%h expected c0/03", dout_m, dout_l);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int b, e;
        dout_rdy = 1'b1;
        send_partial(4);
        checks++;
        if (busy_m !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy busy=%b expected 1", busy_m);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_m, vld_m, busy_m, ovr_m, ferr_m, dout_l, busy_l} !== '0) begin
            errors++;
            $display("FAIL rstmid_async dout=%h vld=%b busy=%b ovr=%b ferr=%b expected all 0",
                     dout_m, vld_m, busy_m, ovr_m, ferr_m);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        send_word(8'h81, 0, 1'b1, 1'b0, b, e);
        checks++;
        if (vld_m !== 1'b1 || dout_m !== 8'h81 || ovr_m !== 1'b0 || e != 0) begin
            errors++;
            $display("FAIL rstmid_word vld=%b dout=%h ovr=%b frm_err=%0d expected 1/81/0/0",
                     vld_m, dout_m, ovr_m, e);
        end
        tick();
    endtask

    task automatic test_same_edge();
        int b, e;
        dout_rdy = 1'b0;
        send_word(8'h11, 0, 1'b1, 1'b0, b, e);
        send_word(8'h22, 0, 1'b1, 1'b1, b, e);
        checks++;
        if (vld_m !== 1'b1 || dout_m !== 8'h22 || ovr_m !== 1'b0 || q_m.size() != 1) begin
            errors++;
            $display("FAIL same_edge vld=%b dout=%h ovr=%b pending=%0d expected 1/22/0/1",
                     vld_m, dout_m, ovr_m, q_m.size());
        end
        tick();
        checks++;
        if (vld_m !== 1'b0) begin
            errors++;
            $display("FAIL same_edge_drain vld=%b expected 0", vld_m);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gapped();
        test_overrun();
        test_abort();
        test_bit_order();
        test_reset_mid();
        test_same_edge();
        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover msb=%0d lsb=%0d expected 0/0", q_m.size(), q_l.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
